// File: rtl/pac_axi_wr_responder.sv
// AXI4 write-only responder: accepts one INCR burst of 64-byte beats at a time into a
// line-addressed local SRAM window and returns a single B response per burst.
module pac_axi_wr_responder #(
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                      axi4_mm_clk,
  input  logic                      axi4_mm_rst_n,
  input  logic [63:0]               win_base_addr,
  input  logic [11:0]               awid,
  input  logic [63:0]               awaddr,
  input  logic [9:0]                awlen,
  input  logic [2:0]                awsize,
  input  logic [1:0]                awburst,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [511:0]              wdata,
  input  logic [63:0]               wstrb,
  input  logic                      wlast,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [11:0]               bid,
  output logic [1:0]                bresp,
  output logic [3:0]                buser,
  output logic                      bvalid,
  input  logic                      bready,
  output logic                      mem_wr_en,
  output logic [MEM_ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [511:0]              mem_wr_data,
  output logic [63:0]               mem_wr_be,
  output logic [31:0]               burst_count,
  output logic [15:0]               err_count
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [64:0] WINDOW_LINES = 65'(1) << MEM_ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t state_reg, state_next;

  // Holds awready low for the first cycle after reset release.
  logic live_reg;

  logic [11:0]               id_reg;
  logic [9:0]                len_reg;
  logic [1:0]                status_reg;
  logic [MEM_ADDR_WIDTH-1:0] wr_line_reg;
  logic [9:0]                beat_cnt_reg;
  logic                      over_reg;

  logic                      mem_wr_en_reg;
  logic [MEM_ADDR_WIDTH-1:0] mem_wr_addr_reg;
  logic [511:0]              mem_wr_data_reg;
  logic [63:0]               mem_wr_be_reg;
  logic [31:0]               burst_count_reg;
  logic [15:0]               err_count_reg;

  logic aw_hs, w_hs, b_hs;

  logic [63:0] offset;
  logic [63:0] line_full;
  logic [64:0] end_line;
  logic [1:0]  aw_status;
  logic        beat_writes;
  logic        last_mismatch;

  // Burst classification, evaluated on the AW handshake cycle.
  always_comb begin
    offset    = awaddr - win_base_addr;
    line_full = offset >> 6;
    end_line  = {1'b0, line_full} + {55'b0, awlen};
    aw_status = RESP_OKAY;
    if (awburst != 2'b01 || awsize != 3'd6) begin
      aw_status = RESP_SLVERR;
    end else if (awaddr < win_base_addr || end_line >= WINDOW_LINES) begin
      aw_status = RESP_DECERR;
    end
  end

  always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
    if (!axi4_mm_rst_n) begin
      state_reg <= IDLE;
      live_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      live_reg  <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    awready    = 1'b0;
    wready     = 1'b0;
    bvalid     = 1'b0;
    case (state_reg)
      IDLE: begin
        awready = live_reg;
        if (awvalid && live_reg) begin
          state_next = DATA;
        end
      end
      DATA: begin
        wready = 1'b1;
        if (wvalid && wlast) begin
          state_next = RESP;
        end
      end
      RESP: begin
        bvalid = 1'b1;
        if (bready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign b_hs  = bvalid & bready;

  // over_reg marks that beat index awlen has already been consumed, so any
  // further beat lies past the announced burst length.
  assign beat_writes   = (status_reg == RESP_OKAY) && !over_reg;
  assign last_mismatch = (beat_cnt_reg != len_reg) || over_reg;

  always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
    if (!axi4_mm_rst_n) begin
      id_reg       <= '0;
      len_reg      <= '0;
      status_reg   <= RESP_OKAY;
      wr_line_reg  <= '0;
      beat_cnt_reg <= '0;
      over_reg     <= 1'b0;
    end else begin
      if (aw_hs) begin
        id_reg       <= awid;
        len_reg      <= awlen;
        status_reg   <= aw_status;
        wr_line_reg  <= line_full[MEM_ADDR_WIDTH-1:0];
        beat_cnt_reg <= '0;
        over_reg     <= 1'b0;
      end else if (w_hs) begin
        wr_line_reg  <= wr_line_reg + MEM_ADDR_WIDTH'(1);
        beat_cnt_reg <= beat_cnt_reg + 10'd1;
        if (beat_cnt_reg == len_reg) begin
          over_reg <= 1'b1;
        end
        // Early or late wlast downgrades a good burst; issued writes stay.
        if (wlast && status_reg == RESP_OKAY && last_mismatch) begin
          status_reg <= RESP_SLVERR;
        end
      end
    end
  end

  always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
    if (!axi4_mm_rst_n) begin
      mem_wr_en_reg   <= 1'b0;
      mem_wr_addr_reg <= '0;
      mem_wr_data_reg <= '0;
      mem_wr_be_reg   <= '0;
    end else begin
      mem_wr_en_reg <= 1'b0;
      if (w_hs && beat_writes) begin
        mem_wr_en_reg   <= 1'b1;
        mem_wr_addr_reg <= wr_line_reg;
        mem_wr_data_reg <= wdata;
        mem_wr_be_reg   <= wstrb;
      end
    end
  end

  always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
    if (!axi4_mm_rst_n) begin
      burst_count_reg <= '0;
      err_count_reg   <= '0;
    end else if (b_hs) begin
      burst_count_reg <= burst_count_reg + 32'd1;
      if (status_reg != RESP_OKAY && err_count_reg != 16'hFFFF) begin
        err_count_reg <= err_count_reg + 16'd1;
      end
    end
  end

  assign bid         = id_reg;
  assign bresp       = status_reg;
  assign buser       = 4'b0;
  assign mem_wr_en   = mem_wr_en_reg;
  assign mem_wr_addr = mem_wr_addr_reg;
  assign mem_wr_data = mem_wr_data_reg;
  assign mem_wr_be   = mem_wr_be_reg;
  assign burst_count = burst_count_reg;
  assign err_count   = err_count_reg;

endmodule

// File: tb/tb_pac_axi_wr_responder.sv
// Directed bench for pac_axi_wr_responder: a transaction-level model predicts writes,
// B responses and counters; a per-cycle monitor compares the DUT against it.
module tb_pac_axi_wr_responder;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [63:0]   win_base_addr;
  logic [11:0]   awid;
  logic [63:0]   awaddr;
  logic [9:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          awvalid;
  logic          awready;
  logic [511:0]  wdata;
  logic [63:0]   wstrb;
  logic          wlast;
  logic          wvalid;
  logic          wready;
  logic [11:0]   bid;
  logic [1:0]    bresp;
  logic [3:0]    buser;
  logic          bvalid;
  logic          bready;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [511:0]  mem_wr_data;
  logic [63:0]   mem_wr_be;
  logic [31:0]   burst_count;
  logic [15:0]   err_count;

  always #5 clk = ~clk;

  pac_axi_wr_responder #(.MEM_ADDR_WIDTH(AW)) dut (
    .axi4_mm_clk(clk), .axi4_mm_rst_n(rst_n), .win_base_addr(win_base_addr),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .buser(buser), .bvalid(bvalid), .bready(bready),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_be(mem_wr_be), .burst_count(burst_count), .err_count(err_count)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Transaction-level model state.
  typedef struct {
    logic [AW-1:0] addr;
    logic [511:0]  data;
    logic [63:0]   be;
  } wr_t;

  wr_t             wq[$];
  int unsigned     seen[$];
  int              phase;      // 0 address phase, 1 data phase, 2 response phase
  logic [11:0]     m_id;
  logic [1:0]      m_resp;
  longint unsigned m_line;
  int              m_len;
  int              m_n;
  int unsigned     m_bursts;
  int unsigned     m_errs;
  bit              mon_on = 1'b0;

  function automatic logic [1:0] classify(input logic [63:0] addr, input logic [63:0] base,
                                          input int len, input int size, input int burst);
    longint unsigned line;
    if (burst != 1 || size != 6) return 2'b10;
    if (addr < base) return 2'b11;
    line = (addr - base) / 64;
    if (line + longint'(len) >= (longint'(1) << AW)) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [511:0] mk_data(input int k);
    logic [31:0] w;
    w = 32'hA5A50000 ^ (32'(k) * 32'h01010101);
    return {16{w}};
  endfunction

  // Per-cycle monitor, sampled on the falling edge.
  always @(negedge clk) begin
    wr_t e;
    if (mon_on) begin
      chk("awready", awready, phase == 0);
      chk("wready", wready, phase == 1);
      chk("bvalid", bvalid, phase == 2);
      if (phase == 2) begin
        chk("bid", bid, m_id);
        chk("bresp", bresp, m_resp);
        chk("buser", buser, 0);
      end
      if (wq.size() > 0) begin
        chk("mem_wr_en", mem_wr_en, 1);
        if (mem_wr_en) begin
          e = wq.pop_front();
          chk("mem_wr_addr", mem_wr_addr, e.addr);
          chk("mem_wr_data", mem_wr_data, e.data);
          chk("mem_wr_be", mem_wr_be, e.be);
          seen.push_back(int'(mem_wr_addr));
        end
      end else begin
        chk("mem_wr_en idle", mem_wr_en, 0);
      end
      chk("burst_count", burst_count, m_bursts);
      chk("err_count", err_count, m_errs);
    end
  end

  task automatic do_aw(input logic [11:0] id, input logic [63:0] addr, input logic [9:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int t;
    @(negedge clk); #1;
    wvalid = 0; bready = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1;
    t = 0;
    while (!awready && t < 100) begin @(negedge clk); #1; t++; end
    if (!awready) begin chk("aw_timeout", 0, 1); awvalid = 0; return; end
    @(posedge clk);
    phase  = 1;
    m_id   = id;
    m_resp = classify(addr, win_base_addr, int'(len), int'(size), int'(burst));
    m_line = (addr - win_base_addr) / 64;
    m_len  = int'(len);
    m_n    = 0;
  endtask

  task automatic do_beat(input logic [511:0] data, input logic [63:0] strb, input logic last);
    int t;
    wr_t e;
    @(negedge clk); #1;
    awvalid = 0; bready = 0;
    wdata = data; wstrb = strb; wlast = last; wvalid = 1;
    t = 0;
    while (!wready && t < 100) begin @(negedge clk); #1; t++; end
    if (!wready) begin chk("w_timeout", 0, 1); wvalid = 0; return; end
    @(posedge clk);
    if (m_resp == 2'b00 && m_n <= m_len) begin
      e.addr = AW'(m_line + longint'(m_n));
      e.data = data;
      e.be   = strb;
      wq.push_back(e);
    end
    if (last) begin
      if (m_resp == 2'b00 && m_n != m_len) m_resp = 2'b10;
      phase = 2;
    end
    m_n++;
  endtask

  task automatic do_b(input int hold, output logic [1:0] got);
    int t;
    @(negedge clk); #1;
    awvalid = 0; wvalid = 0; bready = 0;
    repeat (hold) begin @(negedge clk); #1; end
    bready = 1;
    t = 0;
    while (!bvalid && t < 100) begin @(negedge clk); #1; t++; end
    got = bresp;
    if (!bvalid) begin chk("b_timeout", 0, 1); bready = 0; return; end
    @(posedge clk);
    m_bursts++;
    if (m_resp != 2'b00) m_errs++;
    phase = 0;
  endtask

  task automatic idle(input int n);
    @(negedge clk); #1;
    awvalid = 0; wvalid = 0; bready = 0;
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    mon_on = 0;
    awvalid = 0; wvalid = 0; bready = 0;
    rst_n = 0;
    #1;
    chk("rst awready", awready, 0);
    chk("rst wready", wready, 0);
    chk("rst bvalid", bvalid, 0);
    chk("rst bid", bid, 0);
    chk("rst bresp", bresp, 0);
    chk("rst buser", buser, 0);
    chk("rst mem_wr_en", mem_wr_en, 0);
    chk("rst mem_wr_addr", mem_wr_addr, 0);
    chk("rst mem_wr_data", mem_wr_data, 0);
    chk("rst mem_wr_be", mem_wr_be, 0);
    chk("rst burst_count", burst_count, 0);
    chk("rst err_count", err_count, 0);
    phase = 0; m_bursts = 0; m_errs = 0; m_resp = 0;
    wq.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk);
    @(negedge clk);
    chk("awready after release", awready, 1);
    mon_on = 1;
  endtask

  task automatic chk_seen(input string name, input int first, input int n);
    chk({name, " count"}, seen.size(), n);
    for (int i = 0; i < n && i < seen.size(); i++) chk({name, " line"}, seen[i], first + i);
    seen.delete();
  endtask

  logic [1:0] r;

  initial begin
    rst_n = 1; win_base_addr = 64'hA0000;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
    wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
    phase = 0; m_bursts = 0; m_errs = 0; m_resp = 0; m_id = 0; m_line = 0; m_len = 0; m_n = 0;
    #2;
    do_reset();

    // Single-beat good burst at window base.
    do_aw(12'h5, 64'hA0000, 10'd0, 3'd6, 2'b01);
    do_beat(mk_data(1), {64{1'b1}}, 1);
    do_b(0, r);
    idle(1);
    chk("t1 bresp", r, 2'b00);
    chk("t1 burst_count", burst_count, 1);
    chk_seen("t1", 0, 1);

    // Four beats at line 2, B held off for 5 cycles.
    do_aw(12'h6, 64'hA0080, 10'd3, 3'd6, 2'b01);
    for (int i = 0; i < 4; i++) do_beat(mk_data(10 + i), 64'h00FF_0000_0000_FF00 << i, i == 3);
    do_b(5, r);
    idle(1);
    chk("t2 bresp", r, 2'b00);
    chk_seen("t2", 2, 4);

    // Below the window: decode error, no write.
    do_aw(12'h7, 64'h90000, 10'd0, 3'd6, 2'b01);
    do_beat(mk_data(20), {64{1'b1}}, 1);
    do_b(1, r);
    idle(1);
    chk("t3 bresp", r, 2'b11);
    chk("t3 err_count", err_count, 1);
    chk_seen("t3", 0, 0);

    // FIXED burst type: slave error, no writes.
    do_aw(12'h8, 64'hA0000, 10'd1, 3'd6, 2'b00);
    do_beat(mk_data(30), {64{1'b1}}, 0);
    do_beat(mk_data(31), {64{1'b1}}, 1);
    do_b(0, r);
    idle(1);
    chk("t4 bresp", r, 2'b10);
    chk_seen("t4", 0, 0);

    // Early wlast on beat 1 of a 4-beat burst.
    do_aw(12'h9, 64'hA0000, 10'd3, 3'd6, 2'b01);
    do_beat(mk_data(40), 64'h1, 0);
    do_beat(mk_data(41), 64'h3, 1);
    do_b(0, r);
    idle(1);
    chk("t5 bresp", r, 2'b10);
    chk_seen("t5", 0, 2);

    // Late wlast: third beat of a 2-beat burst is dropped.
    do_aw(12'hA, 64'hA0100, 10'd1, 3'd6, 2'b01);
    for (int i = 0; i < 3; i++) do_beat(mk_data(50 + i), {64{1'b1}}, i == 2);
    do_b(0, r);
    idle(1);
    chk("t6 bresp", r, 2'b10);
    chk_seen("t6", 4, 2);

    // Last line of the window is legal; one past it is not.
    do_aw(12'hB, 64'hAFFC0, 10'd0, 3'd6, 2'b01);
    do_beat(mk_data(60), {64{1'b1}}, 1);
    do_b(0, r);
    idle(1);
    chk("t7 bresp", r, 2'b00);
    chk_seen("t7", 1023, 1);
    do_aw(12'hC, 64'hAFFC0, 10'd1, 3'd6, 2'b01);
    do_beat(mk_data(61), {64{1'b1}}, 0);
    do_beat(mk_data(62), {64{1'b1}}, 1);
    do_b(0, r);
    idle(1);
    chk("t8 bresp", r, 2'b11);
    chk_seen("t8", 0, 0);

    // Wrong beat size.
    do_aw(12'hD, 64'hA0000, 10'd0, 3'd5, 2'b01);
    do_beat(mk_data(70), {64{1'b1}}, 1);
    do_b(0, r);
    idle(1);
    chk("t9 bresp", r, 2'b10);
    chk("t9 burst_count", burst_count, 9);
    chk("t9 err_count", err_count, 6);
    chk_seen("t9", 0, 0);

    // Reset after beat 2 of an 8-beat burst, then stray W traffic in idle.
    do_aw(12'hE, 64'hA0000, 10'd7, 3'd6, 2'b01);
    for (int i = 0; i < 3; i++) do_beat(mk_data(80 + i), {64{1'b1}}, 0);
    do_reset();
    chk_seen("t10 pre", 0, 3);
    @(negedge clk); #1;
    wdata = mk_data(99); wstrb = '1; wlast = 1; wvalid = 1;
    repeat (4) begin @(negedge clk); #1; end
    wvalid = 0;
    chk_seen("t10 post", 0, 0);

    // Fresh burst after reset: counters restart from zero.
    do_aw(12'hF, 64'hA0040, 10'd0, 3'd6, 2'b01);
    do_beat(mk_data(90), 64'hF0F0, 1);
    do_b(2, r);
    idle(2);
    chk("t11 bresp", r, 2'b00);
    chk("t11 burst_count", burst_count, 1);
    chk("t11 err_count", err_count, 0);
    chk_seen("t11", 1, 1);

    idle(2);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/pac_axi_wr_responder.md
PAC_AXI_WR_RESPONDER -- requirements
Module: pac_axi_wr_responder

Interface
REQ-001 SHALL have parameter MEM_ADDR_WIDTH, default 10, giving the local line-address width (window = 2^MEM_ADDR_WIDTH lines of 64 B).
REQ-002 SHALL have port axi4_mm_clk  in  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port axi4_mm_rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port win_base_addr  in  64  byte base of accepted window, 64 B aligned, static during bursts.
REQ-005 SHALL have AW ports awid 12, awaddr 64, awlen 10, awsize 3, awburst 2, awvalid 1 (inputs), and awready 1 (output).
REQ-006 SHALL have W ports wdata 512, wstrb 64, wlast 1, wvalid 1 (inputs), and wready 1 (output).
REQ-007 SHALL have B ports bid 12, bresp 2, buser 4, bvalid 1 (outputs), and bready 1 (input).
REQ-008 SHALL have ports mem_wr_en 1, mem_wr_addr MEM_ADDR_WIDTH, mem_wr_data 512, mem_wr_be 64 (all outputs) forming the local SRAM write port.
REQ-009 SHALL have ports burst_count 32 and err_count 16 (outputs): completed bursts and bursts with non-OKAY bresp.

Function
REQ-010 SHALL implement FSM states IDLE, DATA, RESP.
REQ-011 IDLE: awready=1 and wready=0; AW handshake (awvalid&awready) latches awid, awaddr, awlen; go to DATA next cycle.
REQ-012 SHALL classify the burst at AW handshake: awburst!=2'b01 or awsize!=3'd6 -> SLVERR (2'b10); else line = (awaddr-win_base_addr)>>6, and awaddr<win_base_addr or line+awlen >= 2^MEM_ADDR_WIDTH -> DECERR (2'b11); else OKAY (2'b00).
REQ-013 DATA: wready=1 and awready=0; a beat is each wvalid&wready cycle; beat counter starts at 0.
REQ-014 SHALL write beat n to line (start line + n); mem_wr_en/addr/data/be registered, asserted exactly 1 cycle after the beat handshake, mem_wr_be=wstrb.
REQ-015 SHALL suppress mem_wr_en for all beats of a SLVERR/DECERR burst and for beats with n>awlen.
REQ-016 SHALL leave DATA on the beat with wlast=1; if that beat's n!=awlen (early or late wlast), an OKAY burst becomes SLVERR (writes already issued stand).
REQ-017 RESP: bvalid=1, bid=latched awid, bresp=burst status, buser=4'b0; hold all stable until bready; on bvalid&bready return to IDLE next cycle.
REQ-018 On B handshake SHALL increment burst_count (wrap at 2^32) and, if bresp!=OKAY, err_count (saturate at 16'hFFFF).
REQ-019 SHALL accept at most one outstanding burst; no AW accepted until the B handshake completes.
REQ-020 SHALL ignore wvalid in IDLE and RESP (wready=0); W beats presented before AW wait.
REQ-021 Address arithmetic SHALL be 64-bit unsigned; line index truncated to MEM_ADDR_WIDTH only after range check passes.

Reset
REQ-022 While axi4_mm_rst_n=0: state=IDLE, awready=0, wready=0, bvalid=0, bid=0, bresp=0, buser=0, mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, mem_wr_be=0, burst_count=0, err_count=0.
REQ-023 awready SHALL rise in the first cycle after reset release.
REQ-024 Reset asserted mid-burst SHALL abort immediately: no further mem writes, no B response, counters cleared.

Verification
REQ-025 win_base=0xA0000, AW awaddr=0xA0000 awlen=0 awid=0x5, one beat wlast=1 wstrb=all-ones -> mem_wr_en 1 cycle later at addr 0; bvalid bid=0x5 bresp=00; burst_count=1.
REQ-026 awaddr=0xA0080 awlen=3, 4 beats, bready held low 5 cycles -> writes lines 2..5 in order; B stable until bready; then awready=1 following cycle.
REQ-027 awaddr=0x90000 awlen=0 -> no mem_wr_en; bresp=11; err_count=1.
REQ-028 awburst=2'b00 awlen=1 -> no writes; bresp=10.
REQ-029 awlen=3, wlast on beat 1 -> lines 0,1 written, bresp=10, FSM to RESP after beat 1.
REQ-030 Reset pulsed after beat 2 of awlen=7 burst -> no further writes, bvalid=0, counters 0, awready=1 after release.
